flash_reader: RTL and testbench

Sequential byte-read controller for the board's parallel NOR flash in x8 mode, used to fetch stored score/font data.
- Drives the flash address and control pins.
- Delegates the access-time wait to the team's flash access timer through a start/done pulse pair, then latches the byte.
- Streams bytes to the consumer with a one-cycle valid strobe.
- Sits between display/score logic (requester) and the flash pins plus the access timer.

---
 rtl/flash_pkg.sv | 16 +
 rtl/flash_watchdog.sv | 35 +++
 rtl/flash_reader.sv | 149 ++++++++++++++
 tb/tb_flash_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared constants and state encoding for the NOR flash reader
package flash_pkg;

    localparam int          FLASH_ADDR_W    = 24;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LATCH  = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

endpackage

// File: rtl/flash_watchdog.sv
// rtl/flash_watchdog.sv - 8-bit clear/enable counter with terminal-count flag
module flash_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // tc_o flags that the next enabled increment reaches LIMIT
    assign tc_o = (count_q == 8'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'd0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flash_reader.sv
// rtl/flash_reader.sv - sequential x8 NOR flash byte-read controller with timer handshake
module flash_reader
    import flash_pkg::*;
#(
    parameter int          ADDR_W  = FLASH_ADDR_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_len,
    output logic              busy,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              rd_done,
    output logic              rd_err,
    output logic              timer_start,
    input  logic              timer_done,
    output logic [ADDR_W-1:0] SF_A,
    input  logic [7:0]        SF_D,
    output logic              SF_CE0,
    output logic              SF_OE,
    output logic              SF_WE
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        remaining_q, remaining_d;

    logic              busy_q, data_valid_q, rd_done_q, rd_err_q, timer_start_q;
    logic              ce_n_q, oe_n_q;
    logic [7:0]        data_out_q;
    logic [ADDR_W-1:0] sf_a_q;

    logic wd_clr, wd_en, wd_tc;
    logic capture, err_set, err_clr;
    logic pins_active;

    flash_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk_i (CLK_50MHZ),
        .rst_i (RST),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .tc_o  (wd_tc)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        capture     = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    addr_d      = rd_addr;
                    remaining_d = (rd_len == 8'd0) ? 9'd256 : {1'b0, rd_len};
                    err_clr     = 1'b1;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                wd_clr  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse coinciding with expiry still wins
                if (timer_done) begin
                    capture = 1'b1;
                    state_d = ST_LATCH;
                end else begin
                    wd_en = 1'b1;
                    if (wd_tc) begin
                        err_set = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_LATCH: begin
                remaining_d = remaining_q - 9'd1;
                state_d     = ST_NEXT;
            end
            ST_NEXT: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (remaining_q == 9'd0) ? ST_FINISH : ST_SETUP;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign pins_active = (state_d == ST_SETUP) || (state_d == ST_WAIT) ||
                         (state_d == ST_LATCH) || (state_d == ST_NEXT);

    // Outputs are registered from the next state so each strobe lines up with its state
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            remaining_q   <= 9'd0;
            busy_q        <= 1'b0;
            data_out_q    <= 8'd0;
            data_valid_q  <= 1'b0;
            rd_done_q     <= 1'b0;
            rd_err_q      <= 1'b0;
            timer_start_q <= 1'b0;
            sf_a_q        <= '0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            busy_q        <= (state_d != ST_IDLE);
            data_valid_q  <= (state_d == ST_LATCH);
            rd_done_q     <= (state_d == ST_FINISH);
            timer_start_q <= (state_d == ST_SETUP);
            ce_n_q        <= !pins_active;
            oe_n_q        <= !pins_active;
            if (state_d == ST_SETUP) begin
                sf_a_q <= addr_d;
            end
            if (capture) begin
                data_out_q <= SF_D;
            end
            if (err_clr) begin
                rd_err_q <= 1'b0;
            end else if (err_set) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    assign busy        = busy_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign rd_done     = rd_done_q;
    assign rd_err      = rd_err_q;
    assign timer_start = timer_start_q;
    assign SF_A        = sf_a_q;
    assign SF_CE0      = ce_n_q;
    assign SF_OE       = oe_n_q;
    assign SF_WE       = 1'b1;

endmodule

// File: tb/tb_flash_reader.sv
// tb/tb_flash_reader.sv - scoreboard bench for flash_reader with timer stub and flash model
module tb_flash_reader;

    logic        CLK_50MHZ = 1'b0;
    logic        RST = 1'b1;
    logic        rd_req = 1'b0;
    logic [23:0] rd_addr = 24'd0;
    logic [7:0]  rd_len = 8'd0;
    logic        busy, data_valid, rd_done, rd_err, timer_start;
    logic [7:0]  data_out;
    logic        timer_done = 1'b0;
    logic [23:0] SF_A;
    logic [7:0]  SF_D;
    logic        SF_CE0, SF_OE, SF_WE;

    flash_reader dut (
        .CLK_50MHZ   (CLK_50MHZ),
        .RST         (RST),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_len      (rd_len),
        .busy        (busy),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .rd_done     (rd_done),
        .rd_err      (rd_err),
        .timer_start (timer_start),
        .timer_done  (timer_done),
        .SF_A        (SF_A),
        .SF_D        (SF_D),
        .SF_CE0      (SF_CE0),
        .SF_OE       (SF_OE),
        .SF_WE       (SF_WE)
    );

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    assign SF_D = SF_A[7:0] ^ 8'h5A;

    int cyc = 0;
    always @(posedge CLK_50MHZ) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Access timer stub: done pulses in the D-th cycle after the start strobe
    int stub_d    = 8;
    bit stub_hang = 1'b0;
    int stub_cnt  = 0;
    always @(negedge CLK_50MHZ) begin
        timer_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && !stub_hang) timer_done = 1'b1;
        end
        if (timer_start) stub_cnt = stub_d;
    end

    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
    } byte_t;

    byte_t exp_q[$];
    bit    done_q[$];
    byte_t e_byte;
    bit    e_err;
    int    dv_cnt = 0, done_cnt = 0, ts_cnt = 0;
    int    last_ts_cyc = 0, last_done_cyc = 0;

    always @(negedge CLK_50MHZ) begin
        if (timer_start) begin
            ts_cnt++;
            last_ts_cyc = cyc;
        end
        if (data_valid) begin
            dv_cnt++;
            chk("data_valid_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e_byte = exp_q.pop_front();
                chk("data_out", data_out, e_byte.d);
                chk("SF_A_at_latch", SF_A, e_byte.a);
            end
        end
        if (rd_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            chk("rd_done_expected", done_q.size() != 0, 1);
            if (done_q.size() != 0) begin
                e_err = done_q.pop_front();
                chk("rd_err_at_done", rd_err, e_err);
            end
        end
    end

    task automatic issue(input logic [23:0] a, input logic [7:0] len,
                         input bit err_exp, input bit push_bytes);
        int n;
        logic [23:0] ai;
        byte_t b;
        n = (len == 8'd0) ? 256 : int'(len);
        if (push_bytes) begin
            for (int i = 0; i < n; i++) begin
                ai  = a + 24'(i);
                b.a = ai;
                b.d = ai[7:0] ^ 8'h5A;
                exp_q.push_back(b);
            end
        end
        done_q.push_back(err_exp);
        rd_req  = 1'b1;
        rd_addr = a;
        rd_len  = len;
        @(negedge CLK_50MHZ);
        rd_req  = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge CLK_50MHZ);
            k++;
        end
        chk({name, "_done_in_time"}, done_cnt >= target, 1);
    endtask

    task automatic run(input logic [23:0] a, input logic [7:0] len, input int d, input string name);
        int n, b_ts, b_dv, b_done;
        n      = (len == 8'd0) ? 256 : int'(len);
        stub_d = d;
        b_ts   = ts_cnt;
        b_dv   = dv_cnt;
        b_done = done_cnt;
        issue(a, len, 1'b0, 1'b1);
        wait_done(b_done + 1, n * (d + 4) + 50, name);
        repeat (2) @(negedge CLK_50MHZ);
        chk({name, "_timer_starts"}, ts_cnt - b_ts, n);
        chk({name, "_valid_count"}, dv_cnt - b_dv, n);
        chk({name, "_done_count"}, done_cnt - b_done, 1);
        chk({name, "_all_bytes_seen"}, exp_q.size(), 0);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_ce"}, SF_CE0, 1);
        chk({name, "_idle_oe"}, SF_OE, 1);
    endtask

    initial begin
        int b_ts, b_dv, b_done, k;

        repeat (3) @(negedge CLK_50MHZ);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_rd_done", rd_done, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_timer_start", timer_start, 0);
        chk("rst_sf_a", SF_A, 0);
        chk("rst_ce", SF_CE0, 1);
        chk("rst_oe", SF_OE, 1);
        chk("rst_we", SF_WE, 1);
        RST = 1'b0;
        @(negedge CLK_50MHZ);

        run(24'h000010, 8'd1, 8, "single");
        chk("single_latency", last_done_cyc - last_ts_cyc, 1 + 8 + 2);
        chk("single_sf_a_hold", SF_A, 24'h000010);

        run(24'h0000FE, 8'd4, 8, "burst");
        chk("burst_last_sf_a", SF_A, 24'h000101);

        run(24'hFFFFFF, 8'd0, int'($urandom_range(1, 3)), "wrap256");
        chk("wrap_last_sf_a", SF_A, 24'h0000FE);

        // Watchdog expiry: start strobe, 255 WAIT cycles, then FINISH
        stub_hang = 1'b1;
        stub_d    = 8;
        b_ts = ts_cnt; b_dv = dv_cnt; b_done = done_cnt;
        issue(24'h004000, 8'd3, 1'b1, 1'b0);
        wait_done(b_done + 1, 400, "timeout");
        chk("timeout_latency", last_done_cyc - last_ts_cyc, 256);
        chk("timeout_one_start", ts_cnt - b_ts, 1);
        chk("timeout_no_valid", dv_cnt - b_dv, 0);
        repeat (3) @(negedge CLK_50MHZ);
        chk("timeout_err_sticky", rd_err, 1);
        stub_hang = 1'b0;
        b_done = done_cnt;
        issue(24'h004100, 8'd1, 1'b0, 1'b1);
        chk("err_cleared_on_accept", rd_err, 0);
        wait_done(b_done + 1, 100, "after_timeout");
        repeat (2) @(negedge CLK_50MHZ);

        // Reset in WAIT of the second byte of five
        stub_d = 8;
        b_ts = ts_cnt; b_dv = dv_cnt; b_done = done_cnt;
        issue(24'h002000, 8'd5, 1'b0, 1'b1);
        k = 0;
        while (ts_cnt < b_ts + 2 && k < 100) begin
            @(negedge CLK_50MHZ);
            k++;
        end
        chk("second_start_seen", ts_cnt - b_ts, 2);
        repeat (2) @(negedge CLK_50MHZ);
        RST = 1'b1;
        @(negedge CLK_50MHZ);
        chk("midrst_ce", SF_CE0, 1);
        chk("midrst_oe", SF_OE, 1);
        chk("midrst_busy", busy, 0);
        RST = 1'b0;
        exp_q.delete();
        done_q.delete();
        repeat (30) @(negedge CLK_50MHZ);
        chk("midrst_one_byte_only", dv_cnt - b_dv, 1);
        chk("midrst_no_done", done_cnt - b_done, 0);

        // rd_req while busy must neither disturb nor queue a burst
        stub_d = 4;
        b_ts = ts_cnt; b_dv = dv_cnt; b_done = done_cnt;
        issue(24'h003000, 8'd4, 1'b0, 1'b1);
        repeat (5) @(negedge CLK_50MHZ);
        rd_req  = 1'b1;
        rd_addr = 24'h123456;
        rd_len  = 8'd2;
        @(negedge CLK_50MHZ);
        rd_req  = 1'b0;
        wait_done(b_done + 1, 100, "busy_ignore");
        repeat (20) @(negedge CLK_50MHZ);
        chk("busy_ignore_starts", ts_cnt - b_ts, 4);
        chk("busy_ignore_valids", dv_cnt - b_dv, 4);
        chk("busy_ignore_dones", done_cnt - b_done, 1);
        chk("busy_ignore_idle", busy, 0);

        for (int i = 0; i < 6; i++) begin
            run(24'($urandom), 8'($urandom_range(1, 12)), int'($urandom_range(1, 10)), "random");
        end

        chk("final_queue_empty", exp_q.size() + done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
